ppi8255_bus_sequencer: RTL and testbench

- Synchronous bus master that drives the asynchronous CS/RD/WR/A1/A0/D interface of the team's 8255 peripheral model.
- Two internal requesters (e.g. CPU shim and DMA/test engine) share the one 8255 bus through round-robin arbitration.
- After every reset it writes a configurable control word, then converts each single-cycle request into a timed bus cycle with programmable setup, strobe and hold lengths.
- Returns read data and a completion pulse to the owning requester.

---
 rtl/ppi8255_bus_sequencer_pkg.sv | 30 +++
 rtl/ppi8255_bus_sequencer_rr_arb2.sv | 37 +++
 rtl/ppi8255_bus_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_ppi8255_bus_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi8255_bus_sequencer_pkg.sv
// Shared definitions for the 8255 bus sequencer: state encoding, register
// addresses and control-word layout.
package ppi8255_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [1:0] ADDR_PA   = 2'd0;
  localparam logic [1:0] ADDR_PB   = 2'd1;
  localparam logic [1:0] ADDR_PC   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam logic [7:0] DEF_INIT_CTRL = 8'h9B;
  localparam int         CTRL_MODE_BIT = 7;

  // A control-register write with the mode flag set redefines the port modes;
  // with the flag clear it is a port C bit set/reset and leaves the mode alone.
  function automatic logic is_mode_write(input logic       we,
                                         input logic [1:0] addr,
                                         input logic [7:0] data);
    return we && (addr == ADDR_CTRL) && data[CTRL_MODE_BIT];
  endfunction

endpackage

// File: rtl/ppi8255_bus_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: the tie-break favours the requester that was
// not granted last; the pointer moves only when a grant is actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);

  logic       r_prio;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign o_gnt = w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_upd && (|w_gnt)) begin
      r_prio <= w_gnt[0];
    end
  end

endmodule

// File: rtl/ppi8255_bus_sequencer.sv
// Bus master for the 8255 model: programs the control word after reset, then
// turns arbitrated single-cycle requests into timed CS/RD/WR bus cycles.
module ppi8255_bus_sequencer
  import ppi8255_pkg::*;
#(
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 2,
  parameter int         HOLD_CYC   = 1,
  parameter int         CNT_W      = 4,
  parameter logic [7:0] INIT_CTRL  = DEF_INIT_CTRL
) (
  input  logic       CLK,
  input  logic       RESET_N,
  // Handshake: reqN is a level held until gntN; gntN pulses one cycle when the
  // request is captured; doneN pulses once when that transaction finishes.
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       A1,
  output logic       A0,
  output logic [7:0] D_out,
  output logic       D_drv,
  input  logic [7:0] D_in,
  output logic       busy,
  output logic       init_done,
  output logic [7:0] mode_word,
  output state_t     dbg_state
);

  localparam logic [CNT_W-1:0] C_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_STROBE = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(HOLD_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [1:0]       r_addr;
  logic [7:0]       r_wdata;
  logic             r_owner;
  logic             r_is_init;
  logic             r_illegal;

  logic             r_cs, r_rd, r_wr, r_ddrv, r_busy, r_init_done;
  logic [1:0]       r_a;
  logic [7:0]       r_dout, r_rdata, r_mode_word;
  logic [1:0]       r_gnt, r_done;

  logic [1:0]       w_gnt;
  logic             w_arb_en;
  logic             w_active;
  logic             w_we;
  logic [1:0]       w_addr;
  logic [7:0]       w_wdata;

  assign w_arb_en = (r_state == ST_IDLE) && r_init_done;
  assign w_active = (r_state == ST_SETUP) || (r_state == ST_STROBE) ||
                    (r_state == ST_HOLD);
  assign w_we     = w_gnt[1] ? we1    : we0;
  assign w_addr   = w_gnt[1] ? addr1  : addr0;
  assign w_wdata  = w_gnt[1] ? wdata1 : wdata0;

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RESET_N),
    .i_req ({req1, req0}),
    .i_en  (w_arb_en),
    .i_upd (w_arb_en),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= 2'b00;
      r_wdata     <= 8'h00;
      r_owner     <= 1'b0;
      r_is_init   <= 1'b0;
      r_illegal   <= 1'b0;
      r_cs        <= 1'b1;
      r_rd        <= 1'b1;
      r_wr        <= 1'b1;
      r_a         <= 2'b00;
      r_dout      <= 8'h00;
      r_ddrv      <= 1'b0;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_rdata     <= 8'h00;
      r_mode_word <= 8'h00;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
    end else begin
      // Pin levels are a registered decode of the current phase, so they
      // trail the state register by one cycle.
      r_cs   <= !w_active;
      r_rd   <= !((r_state == ST_STROBE) && !r_we);
      r_wr   <= !((r_state == ST_STROBE) && r_we);
      r_ddrv <= w_active && r_we;
      r_busy <= (r_state != ST_IDLE);
      r_gnt  <= w_gnt;
      r_done <= 2'b00;
      if (r_state == ST_SETUP) begin
        r_a <= r_addr;
        if (r_we) r_dout <= r_wdata;
      end

      case (r_state)
        ST_INIT: begin
          r_we      <= 1'b1;
          r_addr    <= ADDR_CTRL;
          r_wdata   <= INIT_CTRL;
          r_is_init <= 1'b1;
          r_illegal <= 1'b0;
          r_cnt     <= C_SETUP;
          r_state   <= ST_SETUP;
        end
        ST_IDLE: begin
          if (|w_gnt) begin
            r_owner   <= w_gnt[1];
            r_we      <= w_we;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_is_init <= 1'b0;
            // Reading the control register is not a legal 8255 cycle.
            if (!w_we && (w_addr == ADDR_CTRL)) begin
              r_illegal <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_illegal <= 1'b0;
              r_cnt     <= C_SETUP;
              r_state   <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_cnt   <= C_STROBE;
            r_state <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (r_cnt == '0) begin
            if (!r_we) r_rdata <= D_in;
            r_cnt   <= C_HOLD;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          if (r_is_init) r_init_done <= 1'b1;
          else           r_done      <= r_owner ? 2'b10 : 2'b01;
          if (r_illegal) r_rdata <= 8'hFF;
          if (r_is_init || is_mode_write(r_we, r_addr, r_wdata)) begin
            r_mode_word <= r_wdata;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign gnt0      = r_gnt[0];
  assign gnt1      = r_gnt[1];
  assign done0     = r_done[0];
  assign done1     = r_done[1];
  assign rdata     = r_rdata;
  assign CS        = r_cs;
  assign RD        = r_rd;
  assign WR        = r_wr;
  assign A1        = r_a[1];
  assign A0        = r_a[0];
  assign D_out     = r_dout;
  assign D_drv     = r_ddrv;
  assign busy      = r_busy;
  assign init_done = r_init_done;
  assign mode_word = r_mode_word;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ppi8255_bus_sequencer.sv
// Self-checking bench for ppi8255_bus_sequencer: a bus monitor condenses each
// CS-low window into a record that is compared against spec-derived shapes.
module tb_ppi8255_bus_sequencer;
  import ppi8255_pkg::*;

  localparam int         S_CYC     = 1;
  localparam int         STB_CYC   = 2;
  localparam int         H_CYC     = 1;
  localparam logic [7:0] INIT_WORD = 8'h9B;

  typedef struct packed {
    logic [3:0] len;
    logic [3:0] wr_n;
    logic [3:0] rd_n;
    logic [3:0] stb_first;
    logic [1:0] addr;
    logic [7:0] dout;
    logic       drv_all;
    logic       drv_any;
    logic       stable;
    logic [3:0] gap;
  } win_t;
  localparam int WIN_W = $bits(win_t);

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [1:0] req_v = 2'b00;
  logic [1:0] we_v = 2'b00;
  logic [1:0] addr_v [2];
  logic [7:0] wdata_v [2];
  logic [7:0] din_v = 8'h00;

  logic gnt0, gnt1, done0, done1, CS, RD, WR, A1, A0, D_drv, busy, init_done;
  logic [7:0] rdata, D_out, mode_word;
  state_t dbg_state;
  logic [1:0] gnt_v, done_v;
  assign gnt_v  = {gnt1, gnt0};
  assign done_v = {done1, done0};

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_mode, exp_rdata;
  logic [WIN_W-1:0] exp_q[$];

  win_t win_q[$];
  int   rd_idx = 0;
  int   mon_bad = 0;
  int   mon_gnt_cnt = 0;
  int   mon_done_cnt = 0;
  win_t cur;
  logic in_win = 1'b0;
  int   gap_ctr = 15;

  ppi8255_bus_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req0(req_v[0]), .req1(req_v[1]), .we0(we_v[0]), .we1(we_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]), .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .CS(CS), .RD(RD), .WR(WR), .A1(A1), .A0(A0), .D_out(D_out), .D_drv(D_drv),
    .D_in(din_v), .busy(busy), .init_done(init_done), .mode_word(mode_word),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Bus monitor: one record per completed CS-low window
  always @(negedge CLK) begin
    if (!RESET_N) begin
      in_win  = 1'b0;
      gap_ctr = 15;
    end else begin
      if (gnt0 || gnt1) mon_gnt_cnt++;
      if (done0 || done1) mon_done_cnt++;
      if (!CS) begin
        if (!in_win) begin
          cur         = '0;
          cur.gap     = 4'(gap_ctr);
          cur.addr    = {A1, A0};
          cur.dout    = D_out;
          cur.drv_all = 1'b1;
          cur.stable  = 1'b1;
          in_win      = 1'b1;
          gap_ctr     = 0;
        end
        cur.len = cur.len + 4'd1;
        if (!WR) begin
          cur.wr_n = cur.wr_n + 4'd1;
          if (cur.stb_first == 4'd0) cur.stb_first = cur.len;
        end
        if (!RD) begin
          cur.rd_n = cur.rd_n + 4'd1;
          if (cur.stb_first == 4'd0) cur.stb_first = cur.len;
        end
        cur.drv_all = cur.drv_all & D_drv;
        cur.drv_any = cur.drv_any | D_drv;
        if (({A1, A0} != cur.addr) || (D_out != cur.dout)) cur.stable = 1'b0;
      end else begin
        if (in_win) win_q.push_back(cur);
        in_win = 1'b0;
        if (gap_ctr < 15) gap_ctr++;
        if (!RD || !WR) mon_bad++;
      end
    end
  end

  // Reference shape of one bus cycle, from the phase lengths alone
  function automatic win_t exp_win(input logic we, input logic [1:0] a, input logic [7:0] d);
    win_t e;
    e           = '0;
    e.len       = 4'(S_CYC + STB_CYC + H_CYC);
    e.wr_n      = we ? 4'(STB_CYC) : 4'd0;
    e.rd_n      = we ? 4'd0 : 4'(STB_CYC);
    e.stb_first = 4'(S_CYC + 1);
    e.addr      = a;
    e.dout      = we ? d : 8'h00;
    e.drv_all   = we;
    e.drv_any   = we;
    e.stable    = 1'b1;
    return e;
  endfunction

  task automatic compare_window(input string tag);
    win_t o, e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_window: no expected window queued, got %0d recorded", tag, win_q.size());
      return;
    end
    e = exp_q.pop_front();
    if (rd_idx >= win_q.size()) begin
      errors++;
      $display("FAIL %s_window: got no CS-low window, exp %h", tag, e);
      return;
    end
    o = win_q[rd_idx];
    rd_idx++;
    checks++;
    if (o.gap < 4'd2) begin
      errors++;
      $display("FAIL %s_cs_gap: got %0d CS-high cycles, exp >= 2", tag, o.gap);
    end
    o.gap = 4'd0;
    if (!e.drv_any) o.dout = 8'h00;
    if (o !== e) begin
      errors++;
      $display("FAIL %s_window: got len=%0d wr=%0d rd=%0d stb@%0d a=%0d d=%h drv=%b%b st=%b exp len=%0d wr=%0d rd=%0d stb@%0d a=%0d d=%h drv=%b%b st=%b",
               tag, o.len, o.wr_n, o.rd_n, o.stb_first, o.addr, o.dout, o.drv_all, o.drv_any, o.stable,
               e.len, e.wr_n, e.rd_n, e.stb_first, e.addr, e.dout, e.drv_all, e.drv_any, e.stable);
    end
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL %s_init_done: got 0 after %0d cycles, exp 1", tag, n);
      return;
    end
    exp_mode = INIT_WORD;
    checks++;
    if (mode_word !== exp_mode) begin
      errors++;
      $display("FAIL %s_mode_word: got %h exp %h", tag, mode_word, exp_mode);
    end
    exp_q.push_back(exp_win(1'b1, 2'd3, INIT_WORD));
    @(negedge CLK);
    compare_window({tag, "_init"});
  endtask

  // One complete request from requester id, checked end to end
  task automatic do_txn(input int id, input logic we, input logic [1:0] a,
                        input logic [7:0] d, input logic [7:0] din);
    int   n, lat;
    logic illegal;
    illegal = !we && (a == 2'd3);
    @(posedge CLK); #1;
    din_v = din; we_v[id] = we; addr_v[id] = a; wdata_v[id] = d; req_v[id] = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!gnt_v[id] && n < 40);
    req_v[id] = 1'b0;
    checks++;
    if (!gnt_v[id]) begin
      errors++;
      $display("FAIL gnt%0d_timeout: got no grant in %0d cycles", id, n);
      return;
    end
    checks++;
    if (gnt_v[1-id] !== 1'b0) begin
      errors++;
      $display("FAIL gnt_onehot: got %b for requester %0d alone", gnt_v, id);
    end
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!done_v[id] && lat < 20);
    checks++;
    if (!done_v[id]) begin
      errors++;
      $display("FAIL done%0d_timeout: got no done in %0d cycles", id, lat);
      return;
    end
    if (!illegal) begin
      checks++;
      if (lat != S_CYC + STB_CYC + H_CYC + 1) begin
        errors++;
        $display("FAIL done%0d_latency: got %0d exp %0d", id, lat, S_CYC + STB_CYC + H_CYC + 1);
      end
    end
    if (!we) exp_rdata = illegal ? 8'hFF : din;
    if (we && (a == 2'd3) && d[7]) exp_mode = d;
    checks++;
    if (rdata !== exp_rdata) begin
      errors++;
      $display("FAIL rdata: got %h exp %h (id=%0d we=%b a=%0d)", rdata, exp_rdata, id, we, a);
    end
    checks++;
    if (mode_word !== exp_mode) begin
      errors++;
      $display("FAIL mode_word: got %h exp %h (id=%0d we=%b a=%0d d=%h)", mode_word, exp_mode, id, we, a, d);
    end
    @(negedge CLK);
    if (illegal) begin
      checks++;
      if (win_q.size() != rd_idx) begin
        errors++;
        $display("FAIL ctrl_read_bus: got %0d CS windows exp 0", win_q.size() - rd_idx);
        rd_idx = win_q.size();
      end
    end else begin
      exp_q.push_back(exp_win(we, a, d));
      compare_window("txn");
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({CS, RD, WR} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes: got %b exp 111", {CS, RD, WR});
    end
    checks++;
    if ({A1, A0, D_drv} !== 3'b000 || D_out !== 8'h00) begin
      errors++; $display("FAIL reset_bus: got a=%b%b drv=%b d=%h exp 0", A1, A0, D_drv, D_out);
    end
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, init_done} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 000000", {gnt0, gnt1, done0, done1, busy, init_done});
    end
    checks++;
    if (rdata !== 8'h00 || mode_word !== 8'h00) begin
      errors++; $display("FAIL reset_regs: got rdata=%h mode=%h exp 00 00", rdata, mode_word);
    end
    checks++;
    if (dbg_state !== ST_INIT) begin
      errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_INIT);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    exp_mode = 8'h00; exp_rdata = 8'h00;
    wait_init("reset");
    checks++;
    if (mon_gnt_cnt != 0 || mon_done_cnt != 0) begin
      errors++; $display("FAIL init_pulses: got gnt=%0d done=%0d exp 0 0", mon_gnt_cnt, mon_done_cnt);
    end
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, ADDR_PA, 8'h5A, 8'h00);
    do_txn(1, 1'b0, ADDR_PB, 8'h00, 8'hC3);
  endtask

  task automatic test_mode_word();
    do_txn(0, 1'b1, ADDR_CTRL, 8'hB6, 8'h11);
    do_txn(0, 1'b1, ADDR_CTRL, 8'h07, 8'h22);
    do_txn(0, 1'b0, ADDR_CTRL, 8'h00, 8'h33);
  endtask

  task automatic test_back_to_back();
    int left [2];
    int n, who;
    left[0] = 2; left[1] = 2;
    @(posedge CLK); #1;
    we_v = 2'b11; addr_v[0] = ADDR_PA; addr_v[1] = ADDR_PB;
    wdata_v[0] = 8'($urandom); wdata_v[1] = 8'($urandom);
    req_v = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge CLK); n++; end while (gnt_v == 2'b00 && n < 40);
      checks++;
      if (gnt_v == 2'b00) begin
        errors++; $display("FAIL b2b_gnt_timeout: got no grant for slot %0d", k);
        req_v = 2'b00;
        return;
      end
      who = gnt_v[1] ? 1 : 0;
      checks++;
      if (who != (k % 2)) begin
        errors++; $display("FAIL b2b_order: slot %0d got requester %0d exp %0d", k, who, k % 2);
      end
      exp_q.push_back(exp_win(1'b1, addr_v[who], wdata_v[who]));
      req_v[who] = 1'b0;
      left[who]--;
      n = 0;
      do begin @(negedge CLK); n++; end while (!done_v[who] && n < 20);
      checks++;
      if (!done_v[who]) begin
        errors++; $display("FAIL b2b_done_timeout: got no done%0d in slot %0d", who, k);
      end
      if (left[who] > 0) begin
        wdata_v[who] = 8'($urandom);
        req_v[who]   = 1'b1;
      end
    end
    @(negedge CLK);
    for (int k = 0; k < 4; k++) compare_window("b2b");
  endtask

  task automatic test_random();
    int         id;
    logic       we;
    logic [1:0] a;
    for (int i = 0; i < 16; i++) begin
      id = int'($urandom_range(1, 0));
      we = 1'($urandom_range(1, 0));
      a  = 2'($urandom_range(3, 0));
      do_txn(id, we, a, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    int n, done_before;
    @(posedge CLK); #1;
    we_v[0] = 1'b1; addr_v[0] = ADDR_PC; wdata_v[0] = 8'($urandom); req_v[0] = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!gnt0 && n < 40);
    req_v[0] = 1'b0;
    n = 0;
    while (WR && n < 20) begin @(negedge CLK); n++; end
    checks++;
    if (WR) begin
      errors++; $display("FAIL midreset_strobe: got WR high after %0d cycles exp low", n);
      return;
    end
    done_before = mon_done_cnt;
    #1 RESET_N = 1'b0;
    #1;
    checks++;
    if ({CS, WR, init_done} !== 3'b110) begin
      errors++; $display("FAIL midreset_async: got cs=%b wr=%b init=%b exp 1 1 0", CS, WR, init_done);
    end
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    exp_mode = 8'h00; exp_rdata = 8'h00;
    wait_init("midreset");
    checks++;
    if (mon_done_cnt != done_before) begin
      errors++; $display("FAIL midreset_done: got %0d done pulses exp 0", mon_done_cnt - done_before);
    end
    checks++;
    if (rdata !== exp_rdata) begin
      errors++; $display("FAIL midreset_rdata: got %h exp %h", rdata, exp_rdata);
    end
  endtask

  initial begin
    addr_v[0] = 2'd0; addr_v[1] = 2'd0;
    wdata_v[0] = 8'h00; wdata_v[1] = 8'h00;
    exp_mode = 8'h00; exp_rdata = 8'h00;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_mode_word();
    test_random();
    test_reset_mid();
    do_txn(1, 1'b1, ADDR_PB, 8'hA5, 8'h00);
    checks++;
    if (mon_bad != 0) begin
      errors++; $display("FAIL strobe_outside_cs: got %0d cycles exp 0", mon_bad);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
